d_hazard_ctrl: RTL and testbench

Decode-stage controller for the five-stage MIPS pipeline that adds stall generation and D-stage forward selection to instruction decode. Keeps a private scoreboard of destination register and remaining result latency (Tnew) for each downstream stage, plus a multiply/divide busy counter. Drives the extender and PC-select controls, the pipeline stall line, and the forward muxes of the D-stage comparator and `jr` target.

---
 rtl/d_hazard_ctrl_pkg.sv | 71 +++++++
 rtl/d_hazard_ctrl_instr_class.sv | 116 +++++++++++
 rtl/d_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_d_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// Holds opcode/funct codes (including the multiply/divide group), the
// extender and PC-select codes, Tuse/Tnew codes and the decoded-instruction
// record produced by instr_class and consumed by d_hazard_ctrl.
package d_hazard_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Extender select: sign, zero (unsigned), load-upper (half shift)
  typedef enum logic [1:0] {
    SE = 2'd0,
    UE = 2'd1,
    HE = 2'd2
  } ext_op_e;

  // PC select: sequential PC+4, branch/jump target, register target
  typedef enum logic [1:0] {
    PC4  = 2'd0,
    NPC  = 2'd1,
    JRPC = 2'd2
  } pc_sel_e;

  // Tuse: cycles until the operand is consumed; 3 means never read.
  typedef logic [1:0] tuse_t;
  localparam tuse_t TUSE_0    = 2'd0;
  localparam tuse_t TUSE_1    = 2'd1;
  localparam tuse_t TUSE_2    = 2'd2;
  localparam tuse_t TUSE_NONE = 2'd3;

  // Tnew at E entry: cycles until the result is forwardable.
  typedef logic [1:0] tnew_t;
  localparam tnew_t TNEW_0 = 2'd0;
  localparam tnew_t TNEW_1 = 2'd1;
  localparam tnew_t TNEW_2 = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    tuse_t      tuse_rs;
    tuse_t      tuse_rt;
    logic [4:0] dst;
    tnew_t      tnew;
    logic       is_md;       // any HI/LO-unit instruction
    logic       is_mdstart;  // mult/div: starts the busy window
    ext_op_e    ext_op;
    pc_sel_e    pc_sel;
    logic       isj;
    logic       isbr;
  } dec_t;

endpackage

// File: rtl/d_hazard_ctrl_instr_class.sv
// instr_class: pure combinational decode of one instruction word.
// Ports:
//   ir_i   in  32  instruction word
//   dec_o  out     decoded record (Tuse per operand, destination, Tnew,
//                  MD flags, extender/PC-select controls, jump/branch flags)
// Unknown opcodes and functs decode as a nop (no operands, no destination).
module instr_class
  import d_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_EN = 1
) (
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode = ir_i[31:26];
  assign funct  = ir_i[5:0];
  assign rt     = ir_i[20:16];
  assign rd     = ir_i[15:11];

  // rs and shamt do not affect classification; the top compares rs itself.
  assign unused_fields = ^{ir_i[25:21], ir_i[10:6]};

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // an output unassigned, which would otherwise infer a latch.
    dec_o         = '0;
    dec_o.tuse_rs = TUSE_NONE;
    dec_o.tuse_rt = TUSE_NONE;
    dec_o.ext_op  = SE;
    dec_o.pc_sel  = PC4;

    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU, FN_SUBU: begin
            dec_o.tuse_rs = TUSE_1;
            dec_o.tuse_rt = TUSE_1;
            dec_o.dst     = rd;
            dec_o.tnew    = TNEW_1;
          end
          FN_JR: begin
            dec_o.tuse_rs = TUSE_0;
            dec_o.pc_sel  = JRPC;
          end
          FN_MULT, FN_DIV: begin
            if (MD_EN != 0) begin
              dec_o.tuse_rs    = TUSE_1;
              dec_o.tuse_rt    = TUSE_1;
              dec_o.is_md      = 1'b1;
              dec_o.is_mdstart = 1'b1;
            end
          end
          FN_MFHI, FN_MFLO: begin
            if (MD_EN != 0) begin
              dec_o.dst   = rd;
              dec_o.tnew  = TNEW_1;
              dec_o.is_md = 1'b1;
            end
          end
          FN_MTHI, FN_MTLO: begin
            if (MD_EN != 0) begin
              dec_o.tuse_rs = TUSE_1;
              dec_o.is_md   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        dec_o.tuse_rs = TUSE_1;
        dec_o.dst     = rt;
        dec_o.tnew    = TNEW_1;
        dec_o.ext_op  = UE;
      end
      OP_LUI: begin
        dec_o.dst    = rt;
        dec_o.tnew   = TNEW_1;
        dec_o.ext_op = HE;
      end
      OP_LW: begin
        dec_o.tuse_rs = TUSE_1;
        dec_o.dst     = rt;
        dec_o.tnew    = TNEW_2;
      end
      OP_SW: begin
        dec_o.tuse_rs = TUSE_1;
        dec_o.tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        dec_o.tuse_rs = TUSE_0;
        dec_o.tuse_rt = TUSE_0;
        dec_o.pc_sel  = NPC;
        dec_o.isbr    = 1'b1;
      end
      OP_JAL: begin
        dec_o.dst    = REG_RA;
        dec_o.tnew   = TNEW_0;
        dec_o.pc_sel = NPC;
        dec_o.isj    = 1'b1;
      end
      OP_J: begin
        dec_o.pc_sel = NPC;
        dec_o.isj    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/d_hazard_ctrl.sv
// d_hazard_ctrl: decode-stage controller with stall generation and D-stage
// forward selection for a five-stage MIPS pipeline.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   IR_D     in   instruction currently in D
//   Zero     in   D comparator result (rs == rt)
//   EXTOp    out  extender select (SE/UE/HE), 0 while stalled
//   PCSel    out  PC select (PC4/NPC/JRPC), 0 while stalled
//   isj      out  j/jal in D, 0 while stalled
//   isb      out  taken beq in D, 0 while stalled
//   stall    out  freeze F/D and inject a bubble into E
//   fwd_rs   out  rs forward source: 0 = register file, k+1 = entry k
//   fwd_rt   out  rt forward source, same encoding
//   md_busy  out  multiply/divide unit still computing
// A private scoreboard mirrors the destination and remaining Tnew of each
// downstream stage (entry 0 = E).
module d_hazard_ctrl
  import d_hazard_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned MD_EN    = 1,
  parameter int unsigned MD_LAT   = 5,
  parameter int unsigned FWD_W    = $clog2(N_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      IR_D,
  input  logic             Zero,
  output logic [1:0]       EXTOp,
  output logic [1:0]       PCSel,
  output logic             isj,
  output logic             isb,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_rs,
  output logic [FWD_W-1:0] fwd_rt,
  output logic             md_busy
);

  dec_t             dec;
  logic [4:0]       rs;
  logic [4:0]       rt;

  logic [4:0]        sb_dst_q  [N_STAGES];
  logic [4:0]        sb_dst_d  [N_STAGES];
  logic [TNEW_W-1:0] sb_tnew_q [N_STAGES];
  logic [TNEW_W-1:0] sb_tnew_d [N_STAGES];
  logic              e0_md_q, e0_md_d;   // mult/div currently in E
  logic [3:0]        md_cnt_q, md_cnt_d;

  logic             stall_sb;
  logic             stall_md;
  logic [FWD_W-1:0] fwd_rs_c;
  logic [FWD_W-1:0] fwd_rt_c;

  instr_class #(.MD_EN(MD_EN)) u_instr_class (
    .ir_i  (IR_D),
    .dec_o (dec)
  );

  assign rs = IR_D[25:21];
  assign rt = IR_D[20:16];

  // Scoreboard compare. The loop runs from the oldest entry down so the
  // youngest (smallest k) ready match wins the forward select.
  always_comb begin
    stall_sb = 1'b0;
    fwd_rs_c = '0;
    fwd_rt_c = '0;
    for (int k = int'(N_STAGES) - 1; k >= 0; k--) begin
      if (sb_dst_q[k] != REG_ZERO) begin
        if (sb_dst_q[k] == rs) begin
          if (int'(dec.tuse_rs) < int'(sb_tnew_q[k])) stall_sb = 1'b1;
          if (sb_tnew_q[k] == '0) fwd_rs_c = FWD_W'(k + 1);
        end
        if (sb_dst_q[k] == rt) begin
          if (int'(dec.tuse_rt) < int'(sb_tnew_q[k])) stall_sb = 1'b1;
          if (sb_tnew_q[k] == '0) fwd_rt_c = FWD_W'(k + 1);
        end
      end
    end
  end

  // The E-entry flag covers the cycle a mult/div spends in E; the counter
  // then covers the MD_LAT cycles the unit is busy after it leaves E.
  assign md_busy  = (md_cnt_q != 4'd0);
  assign stall_md = dec.is_md & (md_busy | e0_md_q);
  assign stall    = stall_sb | stall_md;

  assign EXTOp  = stall ? 2'd0 : dec.ext_op;
  assign PCSel  = stall ? 2'd0 : dec.pc_sel;
  assign isj    = ~stall & dec.isj;
  assign isb    = ~stall & dec.isbr & Zero;
  assign fwd_rs = fwd_rs_c;
  assign fwd_rt = fwd_rt_c;

  always_comb begin
    sb_dst_d[0]  = stall ? REG_ZERO : dec.dst;
    sb_tnew_d[0] = stall ? '0 : TNEW_W'(dec.tnew);
    for (int k = 1; k < int'(N_STAGES); k++) begin
      sb_dst_d[k]  = sb_dst_q[k-1];
      sb_tnew_d[k] = (sb_tnew_q[k-1] == '0) ? '0 : sb_tnew_q[k-1] - TNEW_W'(1);
    end
    e0_md_d = ~stall & dec.is_mdstart;
    if (e0_md_q)             md_cnt_d = 4'(MD_LAT);
    else if (md_cnt_q != 0)  md_cnt_d = md_cnt_q - 4'd1;
    else                     md_cnt_d = 4'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the scoreboard array is reset entry by entry: unlike a RAM,
      // every entry feeds the stall logic from the first cycle.
      for (int k = 0; k < int'(N_STAGES); k++) begin
        sb_dst_q[k]  <= REG_ZERO;
        sb_tnew_q[k] <= '0;
      end
      e0_md_q  <= 1'b0;
      md_cnt_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every entry shifts from the
      // pre-edge values, independent of statement order.
      sb_dst_q  <= sb_dst_d;
      sb_tnew_q <= sb_tnew_d;
      e0_md_q   <= e0_md_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Self-checking bench for d_hazard_ctrl: directed scenarios plus randomized
// instruction streams compared against an age-based pipeline model.
module tb_d_hazard_ctrl;
  import d_hazard_ctrl_pkg::*;

  localparam int N_STAGES = 3;
  localparam int TNEW_W   = 2;
  localparam int MD_LAT   = 5;
  localparam int FWD_W    = $clog2(N_STAGES + 1);

  logic             clk, reset_n, zero;
  logic [31:0]      ir_d;
  logic [1:0]       ext_op, pc_sel;
  logic             isj, isb, stall, md_busy;
  logic [FWD_W-1:0] fwd_rs, fwd_rt;

  d_hazard_ctrl #(
    .N_STAGES(N_STAGES), .TNEW_W(TNEW_W), .MD_EN(1), .MD_LAT(MD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .IR_D(ir_d), .Zero(zero),
    .EXTOp(ext_op), .PCSel(pc_sel), .isj(isj), .isb(isb), .stall(stall),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_JAL, K_J, K_BEQ, K_LW, K_SW,
    K_MULT, K_DIV, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_COUNT
  } kind_e;

  typedef struct { kind_e kind; logic [31:0] ir; } instr_t;
  typedef struct {
    int tuse_rs, tuse_rt, dst, tnew;
    bit md, mdstart;
    int ext, pc;
    bit j, br;
  } attr_t;
  typedef struct { int dst; int tnew0; bit mdstart; } rec_t;

  // Model state: pipe[j] is the instruction that left D j+1 cycles ago.
  rec_t   pipe[$];
  int     now;
  int     md_issue;
  int     checks, errors;
  instr_t cur;
  logic   cur_zero;
  bit     exp_stall;
  int     last_fwd_rs, last_fwd_rt, last_pc, last_isb, busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic instr_t mk(kind_e k, int rs, int rt, int rd, int imm);
    instr_t in;
    in.kind = k;
    case (k)
      K_ADDU: in.ir = rtype(rs, rt, rd, FN_ADDU);
      K_SUBU: in.ir = rtype(rs, rt, rd, FN_SUBU);
      K_JR:   in.ir = rtype(rs, rt, rd, FN_JR);
      K_MULT: in.ir = rtype(rs, rt, rd, FN_MULT);
      K_DIV:  in.ir = rtype(rs, rt, rd, FN_DIV);
      K_MFHI: in.ir = rtype(0, 0, rd, FN_MFHI);
      K_MFLO: in.ir = rtype(0, 0, rd, FN_MFLO);
      K_MTHI: in.ir = rtype(rs, 0, 0, FN_MTHI);
      K_MTLO: in.ir = rtype(rs, 0, 0, FN_MTLO);
      K_ORI:  in.ir = {OP_ORI, 5'(rs), 5'(rt), 16'(imm)};
      K_LUI:  in.ir = {OP_LUI, 5'(rs), 5'(rt), 16'(imm)};
      K_LW:   in.ir = {OP_LW,  5'(rs), 5'(rt), 16'(imm)};
      K_SW:   in.ir = {OP_SW,  5'(rs), 5'(rt), 16'(imm)};
      K_BEQ:  in.ir = {OP_BEQ, 5'(rs), 5'(rt), 16'(imm)};
      K_JAL:  in.ir = {OP_JAL, 5'(rs), 5'(rt), 16'(imm)};
      K_J:    in.ir = {OP_J,   5'(rs), 5'(rt), 16'(imm)};
      default: begin
        case ($urandom_range(0, 2))
          0:       in.ir = 32'h0;
          1:       in.ir = {6'h3F, 5'(rs), 5'(rt), 16'(imm)};
          default: in.ir = rtype(rs, rt, rd, 6'h25);
        endcase
      end
    endcase
    return in;
  endfunction

  // Instruction-class properties, looked up by the kind the bench generated.
  function automatic attr_t attrs(instr_t in);
    attr_t a;
    int rt, rd;
    rt = int'(in.ir[20:16]);
    rd = int'(in.ir[15:11]);
    a.tuse_rs = 3; a.tuse_rt = 3; a.dst = 0; a.tnew = 0;
    a.md = 0; a.mdstart = 0; a.ext = int'(SE); a.pc = int'(PC4); a.j = 0; a.br = 0;
    case (in.kind)
      K_ADDU, K_SUBU: begin a.tuse_rs = 1; a.tuse_rt = 1; a.dst = rd; a.tnew = 1; end
      K_JR:   begin a.tuse_rs = 0; a.pc = int'(JRPC); end
      K_ORI:  begin a.tuse_rs = 1; a.dst = rt; a.tnew = 1; a.ext = int'(UE); end
      K_LUI:  begin a.dst = rt; a.tnew = 1; a.ext = int'(HE); end
      K_LW:   begin a.tuse_rs = 1; a.dst = rt; a.tnew = 2; end
      K_SW:   begin a.tuse_rs = 1; a.tuse_rt = 2; end
      K_BEQ:  begin a.tuse_rs = 0; a.tuse_rt = 0; a.pc = int'(NPC); a.br = 1; end
      K_JAL:  begin a.dst = 31; a.tnew = 0; a.pc = int'(NPC); a.j = 1; end
      K_J:    begin a.pc = int'(NPC); a.j = 1; end
      K_MULT, K_DIV: begin a.tuse_rs = 1; a.tuse_rt = 1; a.md = 1; a.mdstart = 1; end
      K_MFHI, K_MFLO: begin a.dst = rd; a.tnew = 1; a.md = 1; end
      K_MTHI, K_MTLO: begin a.tuse_rs = 1; a.md = 1; end
      default: ;
    endcase
    return a;
  endfunction

  function automatic instr_t nop0();
    instr_t in;
    in.kind = K_NOP;
    in.ir   = 32'h0;
    return in;
  endfunction

  function automatic int pick_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 31 : v;
  endfunction

  task automatic model_reset();
    pipe.delete();
    now      = 0;
    md_issue = -100;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    attr_t a;
    rec_t  r;
    int    rs, rt, frs, frt, t, age;
    bit    hz, busy, mdstall;
    @(negedge clk);
    a  = attrs(cur);
    rs = int'(cur.ir[25:21]);
    rt = int'(cur.ir[20:16]);
    hz = 0; frs = 0; frt = 0;
    for (int j = 0; j < pipe.size(); j++) begin
      t = pipe[j].tnew0 - j;
      if (t < 0) t = 0;
      if (pipe[j].dst != 0) begin
        if (pipe[j].dst == rs) begin
          if (a.tuse_rs < t) hz = 1;
          if (t == 0 && frs == 0) frs = j + 1;
        end
        if (pipe[j].dst == rt) begin
          if (a.tuse_rt < t) hz = 1;
          if (t == 0 && frt == 0) frt = j + 1;
        end
      end
    end
    age       = now - md_issue;
    busy      = (age >= 2) && (age <= MD_LAT + 1);
    mdstall   = a.md && (busy || (pipe.size() > 0 && pipe[0].mdstart));
    exp_stall = hz || mdstall;

    check("stall",   stall,   exp_stall);
    check("fwd_rs",  fwd_rs,  frs);
    check("fwd_rt",  fwd_rt,  frt);
    check("md_busy", md_busy, busy);
    check("extop",   ext_op,  exp_stall ? 0 : a.ext);
    check("pcsel",   pc_sel,  exp_stall ? 0 : a.pc);
    check("isj",     isj,     !exp_stall && a.j);
    check("isb",     isb,     !exp_stall && a.br && cur_zero);
    last_fwd_rs = int'(fwd_rs);
    last_fwd_rt = int'(fwd_rt);
    last_pc     = int'(pc_sel);
    last_isb    = int'(isb);
    if (md_busy) busy_seen++;

    @(posedge clk);
    if (exp_stall) begin
      r.dst = 0; r.tnew0 = 0; r.mdstart = 0;
    end else begin
      r.dst = a.dst; r.tnew0 = a.tnew; r.mdstart = a.mdstart;
      if (a.mdstart) md_issue = now;
    end
    pipe.push_front(r);
    if (pipe.size() > N_STAGES) void'(pipe.pop_back());
    now++;
    #1;
  endtask

  task automatic apply(input instr_t in, input logic z);
    cur = in; cur_zero = z;
    ir_d = in.ir; zero = z;
  endtask

  // Hold an instruction in D until it leaves; returns the stall cycles seen.
  task automatic issue(input instr_t in, input logic z, output int stalls);
    apply(in, z);
    stalls = 0;
    cycle();
    while (exp_stall) begin
      stalls++;
      if (stalls > 40) begin
        check("stall_bound", stalls, 40);
        break;
      end
      cycle();
    end
  endtask

  task automatic drain(input int n);
    int st;
    repeat (n) issue(nop0(), 1'b0, st);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    checks = 0; errors = 0;
    reset_n = 1'b1; ir_d = 32'h0; zero = 1'b0;
    cur = nop0(); cur_zero = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("rst_stall",   stall,   0);
    check("rst_fwd_rs",  fwd_rs,  0);
    check("rst_fwd_rt",  fwd_rt,  0);
    check("rst_extop",   ext_op,  0);
    check("rst_pcsel",   pc_sel,  0);
    check("rst_isj",     isj,     0);
    check("rst_isb",     isb,     0);
    check("rst_md_busy", md_busy, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // addu straight after reset: no hazard, default controls.
    issue(mk(K_ADDU, 1, 2, 3, 0), 1'b0, st);
    check("addu_stalls", st, 0);
    check("addu_fwd_rs", last_fwd_rs, 0);
    check("addu_fwd_rt", last_fwd_rt, 0);
    check("addu_pcsel",  last_pc, 0);

    // lw $1 -> beq $1,$2: two stalls, then forwarded from W.
    drain(4);
    issue(mk(K_LW, 0, 1, 0, 0), 1'b0, st);
    issue(mk(K_BEQ, 1, 2, 0, 4), 1'b0, st);
    check("lw_beq_stalls", st, 2);
    check("lw_beq_fwd_rs", last_fwd_rs, 3);
    check("lw_beq_fwd_rt", last_fwd_rt, 0);

    // addu $3 -> jr $3: one stall, then forwarded from M.
    drain(4);
    issue(mk(K_ADDU, 1, 2, 3, 0), 1'b0, st);
    issue(mk(K_JR, 3, 0, 0, 0), 1'b0, st);
    check("addu_jr_stalls", st, 1);
    check("addu_jr_fwd_rs", last_fwd_rs, 2);
    check("addu_jr_pcsel",  last_pc, int'(JRPC));

    // $0 as destination never stalls or forwards.
    drain(4);
    issue(mk(K_ORI, 0, 0, 0, 5), 1'b0, st);
    issue(mk(K_BEQ, 0, 0, 0, 8), 1'b1, st);
    check("r0_stalls", st, 0);
    check("r0_fwd_rs", last_fwd_rs, 0);
    check("r0_fwd_rt", last_fwd_rt, 0);
    check("r0_isb",    last_isb, 1);

    // mult -> mflo back-to-back.
    drain(10);
    issue(mk(K_MULT, 1, 2, 0, 0), 1'b0, st);
    busy_seen = 0;
    issue(mk(K_MFLO, 0, 0, 4, 0), 1'b0, st);
    check("mult_mflo_stalls", st, MD_LAT + 1);
    check("mult_busy_cycles", busy_seen, MD_LAT);

    // Reset asserted in the middle of a load-use stall with MD busy.
    drain(10);
    issue(mk(K_MULT, 1, 2, 0, 0), 1'b0, st);
    issue(mk(K_LW, 0, 1, 0, 0), 1'b0, st);
    apply(mk(K_BEQ, 1, 2, 0, 4), 1'b0);
    cycle();
    check("pre_rst_stall", stall, 1);
    check("pre_rst_busy",  md_busy, 1);
    #2;
    reset_n = 1'b0;
    apply(nop0(), 1'b0);
    #1;
    check("mid_rst_stall",  stall,   0);
    check("mid_rst_busy",   md_busy, 0);
    check("mid_rst_fwd_rs", fwd_rs,  0);
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    issue(mk(K_ADDU, 1, 2, 1, 0), 1'b0, st);
    check("post_rst_stalls", st, 0);
    check("post_rst_fwd_rs", last_fwd_rs, 0);

    // Random instruction streams over a small register set.
    repeat (1500) begin
      kind_e k;
      k = kind_e'($urandom_range(0, int'(K_COUNT) - 1));
      issue(mk(k, pick_reg(), pick_reg(), pick_reg(), int'($urandom)),
            logic'($urandom_range(0, 1)), st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
